dmem_line_responder: RTL and testbench

//  Memory-side responder for the line-wide DMEM request interface (strobe/addr/rw/data -> done/data).
//  It serves requests from the core-side atomic unit with a LATENCY-cycle fixed delay.

---
 rtl/dmem_line_responder_if.sv | 22 ++
 rtl/dmem_line_responder.sv | 103 ++++++++++
 tb/tb_dmem_line_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_line_responder_if.sv
// Line-wide DMEM request/response bundle between the core-side initiator and the memory responder.
interface dmem_line_responder_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CLSIZE = 128
) ();
    logic              S_DMEM_strobe_i;
    logic [XLEN-1:0]   S_DMEM_addr_i;
    logic              S_DMEM_rw_i;
    logic [CLSIZE-1:0] S_DMEM_data_i;
    logic              S_DMEM_done_o;
    logic [CLSIZE-1:0] S_DMEM_data_o;

    modport master (
        output S_DMEM_strobe_i, S_DMEM_addr_i, S_DMEM_rw_i, S_DMEM_data_i,
        input  S_DMEM_done_o, S_DMEM_data_o
    );

    modport slave (
        input  S_DMEM_strobe_i, S_DMEM_addr_i, S_DMEM_rw_i, S_DMEM_data_i,
        output S_DMEM_done_o, S_DMEM_data_o
    );
endinterface

// File: rtl/dmem_line_responder.sv
// Fixed-latency line-wide memory responder: one request slot, DEPTH-line array,
// done pulse LATENCY cycles after the accepting edge.
module dmem_line_responder #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CLSIZE  = 128,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    dmem_line_responder_if.slave s_dmem
);
    localparam int unsigned OFS  = $clog2(CLSIZE / 8);
    localparam int unsigned IDX  = $clog2(DEPTH);
    localparam int unsigned CNTW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [IDX-1:0]    r_idx;
    logic              r_rw;
    logic [CLSIZE-1:0] r_wdata;
    logic [CLSIZE-1:0] r_rdata;
    logic [CLSIZE-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_access;
    logic              w_done;
    logic              w_unused_addr;

    // Address bits outside the line index are deliberately ignored (offset and alias bits).
    assign w_unused_addr = ^s_dmem.S_DMEM_addr_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: DONE always returns to IDLE so a still-held strobe is not re-accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (s_dmem.S_DMEM_strobe_i) w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == '0)            w_state_nxt = ST_DONE;
            ST_DONE:                             w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Control decode from the registered state; no input-to-done path.
    always_comb begin
        w_accept = 1'b0;
        w_access = 1'b0;
        w_done   = 1'b0;
        w_accept = (r_state == ST_IDLE) && s_dmem.S_DMEM_strobe_i;
        w_access = (r_state == ST_BUSY) && (r_cnt == '0);
        w_done   = (r_state == ST_DONE);
    end

    // Request latch, latency counter and read data register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNTW'(LATENCY - 1);
                r_idx   <= s_dmem.S_DMEM_addr_i[OFS+IDX-1:OFS];
                r_rw    <= s_dmem.S_DMEM_rw_i;
                r_wdata <= s_dmem.S_DMEM_data_i;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            if (w_access && !r_rw) begin
                r_rdata <= r_mem[r_idx];
            end
        end
    end

    // Line array; contents survive reset, an aborted request never reaches w_access.
    always_ff @(posedge clk_i) begin
        if (w_access && r_rw) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign s_dmem.S_DMEM_done_o = w_done;
    assign s_dmem.S_DMEM_data_o = r_rdata;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: LATENCY=2 and LATENCY=1 instances, scoreboarded responses.
module tb_dmem_line_responder;
    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q2[$];
    exp_t q1[$];
    exp_t e2;
    exp_t e1;
    logic [127:0] last_rd2 = '0;
    logic [127:0] last_rd1 = '0;

    localparam logic [127:0] D_BEEF = {4{32'hDEADBEEF}};
    localparam logic [127:0] D_A5   = {16{8'hA5}};
    localparam logic [127:0] D_55   = {16{8'h55}};
    localparam logic [127:0] D_NEW  = {4{32'h12345678}};
    localparam logic [127:0] D_X    = {4{32'h0BADF00D}};
    localparam logic [127:0] D_DROP = {4{32'hC0FFEE11}};
    localparam logic [127:0] D_L1   = {4{32'h5EED1234}};

    dmem_line_responder_if #(.XLEN(32), .CLSIZE(128)) if2 ();
    dmem_line_responder_if #(.XLEN(32), .CLSIZE(128)) if1 ();

    dmem_line_responder #(.XLEN(32), .CLSIZE(128), .DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .s_dmem (if2)
    );

    dmem_line_responder #(.XLEN(32), .CLSIZE(128), .DEPTH(256), .LATENCY(1)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .s_dmem (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, LATENCY=2 instance.
    always @(negedge clk) begin
        if (if2.S_DMEM_done_o) begin
            checks++;
            assert (q2.size() != 0) else begin
                errors++;
                $error("FAIL done2_spurious got done=1 at cyc %0d, required no pending request", cyc);
            end
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                checks++;
                assert (if2.S_DMEM_data_o === e2.data) else begin
                    errors++;
                    $error("FAIL data2 got %h required %h", if2.S_DMEM_data_o, e2.data);
                end
                checks++;
                assert (cyc === e2.cyc) else begin
                    errors++;
                    $error("FAIL done2_cycle got %0d required %0d", cyc, e2.cyc);
                end
            end
        end
    end

    // Response monitor, LATENCY=1 instance.
    always @(negedge clk) begin
        if (if1.S_DMEM_done_o) begin
            checks++;
            assert (q1.size() != 0) else begin
                errors++;
                $error("FAIL done1_spurious got done=1 at cyc %0d, required no pending request", cyc);
            end
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                checks++;
                assert (if1.S_DMEM_data_o === e1.data) else begin
                    errors++;
                    $error("FAIL data1 got %h required %h", if1.S_DMEM_data_o, e1.data);
                end
                checks++;
                assert (cyc === e1.cyc) else begin
                    errors++;
                    $error("FAIL done1_cycle got %0d required %0d", cyc, e1.cyc);
                end
            end
        end
    end

    task automatic drive(input bit sel, input bit stb, input logic [31:0] addr,
                         input bit rw, input logic [127:0] wd);
        if (sel) begin
            if1.S_DMEM_strobe_i = stb;
            if1.S_DMEM_addr_i   = addr;
            if1.S_DMEM_rw_i     = rw;
            if1.S_DMEM_data_i   = wd;
        end else begin
            if2.S_DMEM_strobe_i = stb;
            if2.S_DMEM_addr_i   = addr;
            if2.S_DMEM_rw_i     = rw;
            if2.S_DMEM_data_i   = wd;
        end
    endtask

    task automatic wait_done(input bit sel, input int mode, input logic [31:0] addr,
                             input bit rw, input logic [127:0] wd, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0 && mode == 1) drive(sel, 1'b1, addr ^ 32'h100, rw, ~wd);
            if (i == 0 && mode == 2) drive(sel, 1'b0, addr, rw, wd);
            if (sel ? if1.S_DMEM_done_o : if2.S_DMEM_done_o) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout got no done within 40 cycles, required done", tag);
        end
    endtask

    // One request; mode 0 normal, 1 change addr/data after acceptance, 2 drop strobe after acceptance.
    task automatic req(input bit sel, input logic [31:0] addr, input bit rw,
                       input logic [127:0] wd, input logic [127:0] exp_rd, input int mode,
                       input string tag);
        exp_t e;
        int   lat;
        @(negedge clk);
        lat    = sel ? 1 : 2;
        e.data = rw ? (sel ? last_rd1 : last_rd2) : exp_rd;
        e.cyc  = cyc + 1 + lat;
        if (!rw) begin
            if (sel) last_rd1 = exp_rd;
            else     last_rd2 = exp_rd;
        end
        if (sel) q1.push_back(e);
        else     q2.push_back(e);
        drive(sel, 1'b1, addr, rw, wd);
        wait_done(sel, mode, addr, rw, wd, tag);
        drive(sel, 1'b0, 32'h0, 1'b0, '0);
    endtask

    // AMO-style read then write with strobe held continuously across done (LATENCY=2 instance).
    task automatic amo(input logic [31:0] addr, input logic [127:0] old_d, input logic [127:0] new_d);
        exp_t e;
        @(negedge clk);
        e.data   = old_d;
        e.cyc    = cyc + 3;
        last_rd2 = old_d;
        q2.push_back(e);
        drive(1'b0, 1'b1, addr, 1'b0, '0);
        wait_done(1'b0, 0, addr, 1'b0, '0, "amo_rd");
        e.data = last_rd2;
        e.cyc  = cyc + 4;
        q2.push_back(e);
        drive(1'b0, 1'b1, addr, 1'b1, new_d);
        wait_done(1'b0, 0, addr, 1'b1, new_d, "amo_wr");
        drive(1'b0, 1'b0, 32'h0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, '0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, '0);
        repeat (3) @(negedge clk);

        // Reset state.
        checks++; assert (if2.S_DMEM_done_o === 1'b0) else begin errors++; $error("FAIL rst_done2 got %b required 0", if2.S_DMEM_done_o); end
        checks++; assert (if2.S_DMEM_data_o === '0) else begin errors++; $error("FAIL rst_data2 got %h required 0", if2.S_DMEM_data_o); end
        checks++; assert (if1.S_DMEM_done_o === 1'b0) else begin errors++; $error("FAIL rst_done1 got %b required 0", if1.S_DMEM_done_o); end
        checks++; assert (if1.S_DMEM_data_o === '0) else begin errors++; $error("FAIL rst_data1 got %h required 0", if1.S_DMEM_data_o); end
        rst_n = 1'b1;

        // Read of untouched line after reset, both latencies.
        req(1'b0, 32'h0, 1'b0, '0, '0, 0, "rd0_l2");
        req(1'b1, 32'h0, 1'b0, '0, '0, 0, "rd0_l1");

        // Write then read back; write leaves data_o unchanged.
        req(1'b0, 32'h40, 1'b1, D_BEEF, '0, 0, "wr40");
        req(1'b0, 32'h40, 1'b0, '0, D_BEEF, 0, "rd40");

        // AMO read->write with strobe held, then readback.
        amo(32'h40, D_BEEF, D_NEW);
        req(1'b0, 32'h40, 1'b0, '0, D_NEW, 0, "rd40_amo");

        // Address alias: DEPTH lines apart map to the same entry; low offset bits ignored.
        req(1'b0, 32'h10, 1'b1, D_A5, '0, 0, "wr10");
        req(1'b0, 32'h1010, 1'b0, '0, D_A5, 0, "rd1010");
        req(1'b1, 32'h20, 1'b1, D_L1, '0, 0, "wr20_l1");
        req(1'b1, 32'h2027, 1'b0, '0, D_L1, 0, "rd2027_l1");

        // Inputs changed during BUSY: access uses the latched copy.
        req(1'b0, 32'h200, 1'b1, D_X, '0, 1, "wr200_pert");
        req(1'b0, 32'h200, 1'b0, '0, D_X, 0, "rd200");
        req(1'b0, 32'h300, 1'b0, '0, '0, 0, "rd300");

        // Strobe dropped mid-request still completes.
        req(1'b0, 32'h400, 1'b1, D_DROP, '0, 2, "wr400_drop");
        req(1'b0, 32'h400, 1'b0, '0, D_DROP, 0, "rd400");

        // Reset while BUSY on a write aborts it.
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h80, 1'b1, D_55);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; assert (if2.S_DMEM_done_o === 1'b0) else begin errors++; $error("FAIL abort_done got %b required 0", if2.S_DMEM_done_o); end
            checks++; assert (if2.S_DMEM_data_o === '0) else begin errors++; $error("FAIL abort_data got %h required 0", if2.S_DMEM_data_o); end
        end
        rst_n    = 1'b1;
        last_rd2 = '0;
        last_rd1 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; assert (if2.S_DMEM_done_o === 1'b0) else begin errors++; $error("FAIL abort_post_done got %b required 0", if2.S_DMEM_done_o); end
        end
        req(1'b0, 32'h80, 1'b0, '0, '0, 0, "rd80_abort");

        repeat (4) @(negedge clk);
        checks++; assert (q2.size() === 0) else begin errors++; $error("FAIL q2_drain got %0d required 0", q2.size()); end
        checks++; assert (q1.size() === 0) else begin errors++; $error("FAIL q1_drain got %0d required 0", q1.size()); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
